// File: rtl/game_supervisor.sv
// Game supervisor: lives, distance score, crash pause and sprite blink for a driving game.
// Optional post-respawn invulnerability is enabled by defining GAME_SUPERVISOR_INVULN_EN.
module game_supervisor #(
  parameter int N_OBS        = 6,
  parameter int LIVES        = 3,
  parameter int CRASH_TICKS  = 60,
  parameter int INVULN_TICKS = 90,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic [N_OBS-1:0]   obs_on,
  input  logic [N_OBS-1:0]   hit_vec,
  output logic               alive,
  output logic [1:0]         state,
  output logic [3:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         hit_idx,
  output logic               flash
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         crash_q, crash_d;
  logic [2:0]         fcnt_q, fcnt_d;
  logic               flash_q, flash_d;
  logic               alive_q;

  logic [N_OBS-1:0]   qual;
  logic               hit_any;
  logic [3:0]         first_idx;
  logic               inv_busy, inv_next_busy;
  logic               blink_now, blink_next;

`ifdef GAME_SUPERVISOR_INVULN_EN
  logic [7:0] inv_q, inv_d;
  assign inv_busy      = (inv_q != 8'd0);
  assign inv_next_busy = (inv_d != 8'd0) && (state_d == PLAY);
`else
  assign inv_busy      = 1'b0;
  assign inv_next_busy = 1'b0;
`endif

  assign qual    = hit_vec & obs_on;
  assign hit_any = |qual;

  // Lowest qualifying obstacle wins when several collide at once.
  always_comb begin
    first_idx = 4'd0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (qual[i]) first_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    idx_d   = idx_q;
    crash_d = crash_q;
`ifdef GAME_SUPERVISOR_INVULN_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          lives_d = 4'(LIVES);
          score_d = '0;
          idx_d   = 4'd0;
`ifdef GAME_SUPERVISOR_INVULN_EN
          inv_d   = 8'd0;
`endif
        end
      end
      PLAY: begin
        // A collision on a tick cycle consumes the tick: no score for it.
        if (hit_any && !inv_busy) begin
          idx_d = first_idx;
          if (lives_q > 4'd1) begin
            state_d = CRASH;
            lives_d = lives_q - 4'd1;
            crash_d = 8'(CRASH_TICKS);
          end else begin
            state_d = OVER;
            lives_d = 4'd0;
          end
        end else if (tick) begin
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
`ifdef GAME_SUPERVISOR_INVULN_EN
          if (inv_busy) inv_d = inv_q - 8'd1;
`endif
        end
      end
      CRASH: begin
        if (tick) begin
          if (crash_q == 8'd1) begin
            state_d = PLAY;
            crash_d = 8'd0;
`ifdef GAME_SUPERVISOR_INVULN_EN
            inv_d   = 8'(INVULN_TICKS);
`endif
          end else begin
            crash_d = crash_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink period spans the crash pause and any invulnerability that follows it.
  assign blink_now  = (state_q == CRASH) || inv_busy;
  assign blink_next = (state_d == CRASH) || inv_next_busy;

  always_comb begin
    fcnt_d  = fcnt_q;
    flash_d = flash_q;
    if (!blink_next) begin
      fcnt_d  = 3'd0;
      flash_d = 1'b0;
    end else if (blink_now && tick) begin
      fcnt_d = fcnt_q + 3'd1;
      if (fcnt_q == 3'd7) flash_d = ~flash_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lives_q <= 4'd0;
      score_q <= '0;
      idx_q   <= 4'd0;
      crash_q <= 8'd0;
      fcnt_q  <= 3'd0;
      flash_q <= 1'b0;
      alive_q <= 1'b0;
`ifdef GAME_SUPERVISOR_INVULN_EN
      inv_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      idx_q   <= idx_d;
      crash_q <= crash_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      alive_q <= (state_d == PLAY);
`ifdef GAME_SUPERVISOR_INVULN_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign state   = state_q;
  assign alive   = alive_q;
  assign lives   = lives_q;
  assign score   = score_q;
  assign hit_idx = idx_q;
  assign flash   = flash_q;

endmodule

// File: tb/tb_game_supervisor.sv
// Randomized bench for game_supervisor against a rule-level model; second instance checks score saturation.
module tb_game_supervisor;

  localparam int N_OBS   = 6;
  localparam int LIVES   = 3;
  localparam int CRASH_T = 60;
  localparam int INV_T   = 90;
  localparam int SW      = 16;
`ifdef GAME_SUPERVISOR_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             tick = 1'b0;
  logic [N_OBS-1:0] obs_on = '0;
  logic [N_OBS-1:0] hit_vec = '0;
  logic [N_OBS-1:0] zero_vec = '0;

  logic             alive, flash;
  logic [1:0]       state;
  logic [3:0]       lives, hit_idx;
  logic [SW-1:0]    score;

  logic             s_alive, s_flash;
  logic [1:0]       s_state;
  logic [3:0]       s_lives, s_hit_idx;
  logic [3:0]       s_score;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_state, m_lives, m_score, m_idx, m_crash, m_inv, m_bt;
  int m_small_play, m_small_score;

  game_supervisor #(.N_OBS(N_OBS), .LIVES(LIVES), .CRASH_TICKS(CRASH_T),
                    .INVULN_TICKS(INV_T), .SCORE_W(SW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .obs_on(obs_on), .hit_vec(hit_vec),
    .alive(alive), .state(state), .lives(lives), .score(score),
    .hit_idx(hit_idx), .flash(flash)
  );

  game_supervisor #(.N_OBS(N_OBS), .SCORE_W(4)) u_small (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .obs_on(zero_vec), .hit_vec(zero_vec),
    .alive(s_alive), .state(s_state), .lives(s_lives), .score(s_score),
    .hit_idx(s_hit_idx), .flash(s_flash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_idx = 0;
    m_crash = 0; m_inv = 0; m_bt = 0;
    m_small_play = 0; m_small_score = 0;
  endtask

  function automatic bit blinking(input int st, input int inv);
    return (st == 2) || (st == 1 && inv > 0);
  endfunction

  task automatic model_step(input bit st, input bit tk, input int obs, input int hit);
    int q, low, max_score;
    bit was_blink;
    q = obs & hit;
    low = 0;
    for (int i = N_OBS - 1; i >= 0; i--) if (q[i]) low = i;
    max_score = (1 << SW) - 1;
    was_blink = blinking(m_state, m_inv);
    case (m_state)
      0, 3: if (st) begin
        m_state = 1; m_lives = LIVES; m_score = 0; m_idx = 0; m_inv = 0;
      end
      1: begin
        if (q != 0 && m_inv == 0) begin
          m_idx = low;
          if (m_lives > 1) begin
            m_state = 2; m_lives--; m_crash = CRASH_T;
          end else begin
            m_state = 3; m_lives = 0;
          end
        end else if (tk) begin
          if (m_score < max_score) m_score++;
          if (m_inv > 0) m_inv--;
        end
      end
      default: if (tk) begin
        m_crash--;
        if (m_crash == 0) begin
          m_state = 1;
          m_inv = INV_EN ? INV_T : 0;
        end
      end
    endcase
    // Sprite toggles once per 8 ticks spent in a continuous blink period.
    if (!blinking(m_state, m_inv)) m_bt = 0;
    else if (was_blink && tk) m_bt++;
    if (!m_small_play) begin
      if (st) begin m_small_play = 1; m_small_score = 0; end
    end else if (tk && m_small_score < 15) m_small_score++;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("alive", int'(alive), int'(m_state == 1));
    check("lives", int'(lives), m_lives);
    check("score", int'(score), m_score);
    check("hit_idx", int'(hit_idx), m_idx);
    check("flash", int'(flash), (m_bt / 8) % 2);
    check("small_score", int'(s_score), m_small_score);
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), then check.
  task automatic step(input bit st, input bit tk, input logic [N_OBS-1:0] obs,
                      input logic [N_OBS-1:0] hit);
    start = st; tick = tk; obs_on = obs; hit_vec = hit;
    @(posedge clk);
    model_step(st, tk, int'(obs), int'(hit));
    #1;
    compare_all();
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [N_OBS-1:0] obs, input logic [N_OBS-1:0] hit);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, obs, hit);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    check("rst_flash", int'(flash), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Start then 10 clean ticks
    step(1'b1, 1'b0, '0, '0);
    ticks(10, '0, '0);
    check("d_state", int'(state), 1);
    check("d_alive", int'(alive), 1);
    check("d_lives", int'(lives), 3);
    check("d_score", int'(score), 10);

    // Collision on an inactive obstacle is ignored
    ticks(5, 6'b000000, 6'b000100);
    check("masked_score", int'(score), 15);

    // Two collisions with a coincident tick: lowest index, no score
    step(1'b0, 1'b1, 6'b111111, 6'b010100);
    check("crash_state", int'(state), 2);
    check("crash_lives", int'(lives), 2);
    check("crash_idx", int'(hit_idx), 2);
    check("crash_score", int'(score), 15);
    step(1'b1, 1'b0, 6'b111111, 6'b111111);
    check("crash_start_ign", int'(state), 2);
    ticks(CRASH_T - 1, '0, '0);
    check("crash_hold", int'(state), 2);
    ticks(1, '0, '0);
    check("respawn", int'(state), 1);

    // Remaining lives to game over, then restart
    step(1'b0, 1'b0, 6'b100000, 6'b100000);
    check("crash2_idx", int'(hit_idx), 5);
    ticks(CRASH_T, '0, '0);
    ticks(INV_EN ? INV_T : 0, '0, '0);
    step(1'b0, 1'b0, 6'b001000, 6'b001001);
    check("over_state", int'(state), 3);
    check("over_lives", int'(lives), 0);
    check("over_alive", int'(alive), 0);
    check("over_idx", int'(hit_idx), 3);
    ticks(4, '1, '1);
    check("over_score_hold", int'(score), 15);
    step(1'b1, 1'b0, '0, '0);
    check("restart_state", int'(state), 1);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(score), 0);

    // Collision held across respawn
    step(1'b0, 1'b1, 6'b000010, 6'b000010);
    ticks(CRASH_T, 6'b000010, 6'b000010);
    check("hold_respawn", int'(state), 1);
    ticks(INV_EN ? INV_T : 0, 6'b000010, 6'b000010);
    check("hold_invuln", int'(state), 1);
    step(1'b0, 1'b0, 6'b000010, 6'b000010);
    check("hold_crash", int'(state), 2);

    // Reset asserted mid-crash with the pause counter at 30
    ticks(CRASH_T - 30, '0, '0);
    do_reset();
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_lives", int'(lives), 0);

    // Score saturation on the 4-bit instance
    step(1'b1, 1'b0, '0, '0);
    ticks(20, '0, '0);
    check("small_sat", int'(s_score), 15);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
             N_OBS'($urandom),
             ($urandom_range(0, 15) == 0) ? N_OBS'($urandom) : '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
